// File: rtl/fifo_stream_unpacker_pkg.sv
// fifo_stream_pkg: FSM state codes, header magic and header field positions for fifo_stream_unpacker.
package fifo_stream_pkg;
    typedef logic [1:0] state_t;
    localparam state_t S_HEADER  = 2'd0;
    localparam state_t S_PAYLOAD = 2'd1;
    localparam state_t S_CHECK   = 2'd2;
    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam int HDR_MAGIC_W = 8;
    localparam int HDR_LEN_W   = 16;

    function automatic logic hdr_legal(input logic [7:0] magic, input logic [15:0] len, input int max_len);
        return magic == HDR_MAGIC && len != '0 && {16'd0, len} <= 32'(max_len);
    endfunction
endpackage

// File: rtl/fifo_stream_unpacker_if.sv
// fifo_stream_unpacker_if: FIFO pop port, payload stream and status of the unpacker.
// CHK_ERR exists only when FIFO_STREAM_UNPACKER_CHECKSUM_EN is defined.
interface fifo_stream_unpacker_if #(parameter int DATA_WIDTH = 32);
    logic                  FIFO_nEN;
    logic [DATA_WIDTH-1:0] FIFO_DATA;
    logic                  FIFO_EMPTY;
    logic                  M_VALID;
    logic                  M_READY;
    logic [DATA_WIDTH-1:0] M_DATA;
    logic                  M_LAST;
    logic                  HDR_ERR;
    logic [15:0]           PKT_CNT;
    logic                  BUSY;
`ifdef FIFO_STREAM_UNPACKER_CHECKSUM_EN
    logic                  CHK_ERR;
    modport master (output FIFO_nEN, M_VALID, M_DATA, M_LAST, HDR_ERR, PKT_CNT, BUSY, CHK_ERR,
                    input FIFO_DATA, FIFO_EMPTY, M_READY);
    modport slave  (input FIFO_nEN, M_VALID, M_DATA, M_LAST, HDR_ERR, PKT_CNT, BUSY, CHK_ERR,
                    output FIFO_DATA, FIFO_EMPTY, M_READY);
`else
    modport master (output FIFO_nEN, M_VALID, M_DATA, M_LAST, HDR_ERR, PKT_CNT, BUSY,
                    input FIFO_DATA, FIFO_EMPTY, M_READY);
    modport slave  (input FIFO_nEN, M_VALID, M_DATA, M_LAST, HDR_ERR, PKT_CNT, BUSY,
                    output FIFO_DATA, FIFO_EMPTY, M_READY);
`endif
endinterface

// File: rtl/fifo_stream_unpacker_skid_buffer.sv
// stream_skid_buffer: 2-entry valid/ready buffer with registered output; slot 0 drives the output.
module stream_skid_buffer #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         not_full_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         v0_q, v0_d, v1_q, v1_d, adv;
    logic [W-1:0] d0_q, d0_d, d1_q, d1_d;

    // slot 0 advances when drained or empty; slot 1 is only ever valid behind a valid slot 0
    assign adv = out_ready_i || !v0_q;

    always_comb begin
        v0_d = adv ? (v1_q || in_valid_i) : v0_q;
        d0_d = !adv ? d0_q : v1_q ? d1_q : in_valid_i ? in_data_i : d0_q;
        v1_d = adv ? (v1_q && in_valid_i) : (v1_q || in_valid_i);
        d1_d = (in_valid_i && (v1_q || !adv)) ? in_data_i : d1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            d0_q <= '0;
            d1_q <= '0;
        end else begin
            v0_q <= v0_d;
            v1_q <= v1_d;
            d0_q <= d0_d;
            d1_q <= d1_d;
        end
    end

    assign not_full_o  = !v1_q;
    assign out_valid_o = v0_q;
    assign out_data_o  = d0_q;
endmodule

// File: rtl/fifo_stream_unpacker.sv
// fifo_stream_unpacker: pops length-framed packets from a FWFT FIFO and emits payload as a stream.
// Define FIFO_STREAM_UNPACKER_CHECKSUM_EN to require and verify an XOR trailer word per packet.
module fifo_stream_unpacker
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LEN    = 256
) (
    input  logic                   CLK,
    input  logic                   RST,
    fifo_stream_unpacker_if.master bus
);
`ifdef FIFO_STREAM_UNPACKER_CHECKSUM_EN
    localparam state_t S_DONE = S_CHECK;
`else
    localparam state_t S_DONE = S_HEADER;
`endif

    state_t               state_q, state_d;
    logic [HDR_LEN_W-1:0] len, rem_q, rem_d;
    logic [15:0]          pkt_cnt_q, pkt_cnt_d;
    logic                 hdr_err_q, hdr_err_d, legal, pop, push, not_full, m_valid;
    logic [DATA_WIDTH:0]  m_word;

    assign len   = bus.FIFO_DATA[HDR_LEN_W-1:0];
    assign legal = hdr_legal(bus.FIFO_DATA[DATA_WIDTH-1 -: HDR_MAGIC_W], len, MAX_LEN);
    assign pop   = !RST && !bus.FIFO_EMPTY && (state_q == S_HEADER || state_q == S_CHECK || not_full);
    assign push  = pop && state_q == S_PAYLOAD;

    always_comb begin
        state_d   = state_q;
        rem_d     = push ? rem_q - 1'b1 : rem_q;
        hdr_err_d = pop && state_q == S_HEADER && !legal;
        pkt_cnt_d = pkt_cnt_q + {15'd0, m_valid && bus.M_READY && bus.M_LAST};
        if (pop && state_q == S_HEADER && legal) begin
            state_d = S_PAYLOAD;
            rem_d   = len;
        end
        if (push && rem_q == 16'd1) state_d = S_DONE;
        if (pop && state_q == S_CHECK) state_d = S_HEADER;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_HEADER;
            rem_q     <= '0;
            pkt_cnt_q <= '0;
            hdr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            pkt_cnt_q <= pkt_cnt_d;
            hdr_err_q <= hdr_err_d;
        end
    end

`ifdef FIFO_STREAM_UNPACKER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  chk_err_q, chk_err_d;

    always_comb begin
        acc_d     = state_q == S_HEADER ? '0 : push ? acc_q ^ bus.FIFO_DATA : acc_q;
        chk_err_d = pop && state_q == S_CHECK && bus.FIFO_DATA != acc_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign bus.CHK_ERR = chk_err_q;
`endif

    stream_skid_buffer #(.W(DATA_WIDTH + 1)) u_skid (
        .clk        (CLK),
        .rst        (RST),
        .in_valid_i (push),
        .in_data_i  ({rem_q == 16'd1, bus.FIFO_DATA}),
        .not_full_o (not_full),
        .out_valid_o(m_valid),
        .out_ready_i(bus.M_READY),
        .out_data_o (m_word)
    );

    assign bus.FIFO_nEN = !pop;
    assign bus.M_VALID  = m_valid;
    assign bus.M_DATA   = m_word[DATA_WIDTH-1:0];
    assign bus.M_LAST   = m_word[DATA_WIDTH];
    assign bus.HDR_ERR  = hdr_err_q;
    assign bus.PKT_CNT  = pkt_cnt_q;
    assign bus.BUSY     = state_q != S_HEADER || m_valid;
endmodule
